window3x3_gen: RTL and testbench



---
 rtl/window3x3_gen_pkg.sv | 15 +
 rtl/window3x3_gen_line_buffer.sv | 28 ++
 rtl/window3x3_gen.sv | 112 +++++++++++
 tb/tb_window3x3_gen.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/window3x3_gen_pkg.sv
// Shared types and constants for the 3x3 convolution datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package window3x3_gen_pkg;

    localparam int PIX_W     = 8;
    localparam int DEF_IMG_W = 64;
    localparam int DEF_IMG_H = 64;

    typedef logic [PIX_W-1:0] pix_t;

    // Nine window words, index 0 = p1 (top-left) ... index 8 = p9 (bottom-right).
    typedef pix_t [8:0] win3x3_t;

endpackage

// File: rtl/window3x3_gen_line_buffer.sv
// Single-address line buffer: combinational read, synchronous write at the same address.
// Latency: read is combinational; written data is visible from the next cycle.
// Backpressure: none; the write enable is driven every accepted pixel.
module line_buffer #(
    parameter int DEPTH = 64,
    parameter int W     = 16,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    // Read returns the old contents even when a write to the same address is pending.
    assign rdata = mem[addr];

    // Storage update; contents are never cleared, as nothing reads them before they are rewritten.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/window3x3_gen.sv
// Raster pixel stream to sliding 3x3 window, no border padding.
// Latency: 1 cycle from accepted pixel to its window on p1..p9 / win_valid.
// Backpressure: none; one pixel per clock is accepted whenever pix_valid is high.
module window3x3_gen
    import window3x3_gen_pkg::*;
#(
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H,
    parameter int DW    = PIX_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] pix_in,
    input  logic          pix_valid,
    input  logic          sof,
    output logic [DW-1:0] p1,
    output logic [DW-1:0] p2,
    output logic [DW-1:0] p3,
    output logic [DW-1:0] p4,
    output logic [DW-1:0] p5,
    output logic [DW-1:0] p6,
    output logic [DW-1:0] p7,
    output logic [DW-1:0] p8,
    output logic [DW-1:0] p9,
    output logic          win_valid,
    output logic          frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [CW-1:0] col_eff;
    logic [RW-1:0] row_eff;
    win3x3_t       win_q;

    logic [2*DW-1:0] lb_rd;
    logic [2*DW-1:0] lb_wr;
    logic [DW-1:0]   lb0_rd;
    logic [DW-1:0]   lb1_rd;
    logic            lb_we;

    // sof forces the pixel to (0,0), discarding whatever partial frame the counters track.
    always_comb begin
        col_eff = col;
        row_eff = row;
        if (sof) begin
            col_eff = '0;
            row_eff = '0;
        end
    end

    // Both line buffers share one address, so they live in a single double-width array:
    // low half is row r-1, high half is row r-2, which is fed from the old row r-1 value.
    assign lb0_rd = lb_rd[DW-1:0];
    assign lb1_rd = lb_rd[2*DW-1:DW];
    assign lb_wr  = {lb0_rd, pix_in};
    assign lb_we  = pix_valid && rst;

    line_buffer #(
        .DEPTH (IMG_W),
        .W     (2 * DW)
    ) u_lb (
        .clk   (clk),
        .we    (lb_we),
        .addr  (col_eff),
        .wdata (lb_wr),
        .rdata (lb_rd)
    );

    // Counters, window shift register and registered valid/done flags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            col        <= '0;
            row        <= '0;
            win_q      <= '0;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else if (pix_valid) begin
            win_q      <= {pix_in, win_q[8], win_q[7],
                           lb0_rd, win_q[5], win_q[4],
                           lb1_rd, win_q[2], win_q[1]};
            // Columns 0/1 hold stale pixels from the previous line, so they never qualify.
            win_valid  <= (row_eff >= RW'(2)) && (col_eff >= CW'(2));
            frame_done <= (row_eff == ROW_LAST) && (col_eff == COL_LAST);
            if (col_eff == COL_LAST) begin
                col <= '0;
                row <= (row_eff == ROW_LAST) ? '0 : row_eff + RW'(1);
            end else begin
                col <= col_eff + CW'(1);
                row <= row_eff;
            end
        end else begin
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
        end
    end

    assign p1 = win_q[0];
    assign p2 = win_q[1];
    assign p3 = win_q[2];
    assign p4 = win_q[3];
    assign p5 = win_q[4];
    assign p6 = win_q[5];
    assign p7 = win_q[6];
    assign p8 = win_q[7];
    assign p9 = win_q[8];

endmodule

// File: tb/tb_window3x3_gen.sv
// Bench for window3x3_gen on a 4x4 frame with an image-array reference model.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: n/a; the bench drives pix_valid gaps directly.
module tb_window3x3_gen;

    localparam int W = 4;
    localparam int H = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] pix_in = 8'h00;
    logic       pix_valid = 1'b0;
    logic       sof = 1'b0;
    logic [7:0] p1, p2, p3, p4, p5, p6, p7, p8, p9;
    logic       win_valid;
    logic       frame_done;

    window3x3_gen #(.IMG_W(W), .IMG_H(H), .DW(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .pix_in     (pix_in),
        .pix_valid  (pix_valid),
        .sof        (sof),
        .p1         (p1),
        .p2         (p2),
        .p3         (p3),
        .p4         (p4),
        .p5         (p5),
        .p6         (p6),
        .p7         (p7),
        .p8         (p8),
        .p9         (p9),
        .win_valid  (win_valid),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: the current frame as an image, plus position of the next pixel.
    logic [7:0]  img [H][W];
    int          mr = 0;
    int          mc = 0;
    logic        e_wv;
    logic        e_fd;
    logic [71:0] e_win;
    bit          win_known;

    // Per-scenario observations.
    int          win_cnt;
    int          fd_cnt;
    logic [71:0] first_win;
    logic [71:0] last_win;

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [71:0] dut_win();
        return {p1, p2, p3, p4, p5, p6, p7, p8, p9};
    endfunction

    task automatic clear_obs();
        win_cnt   = 0;
        fd_cnt    = 0;
        first_win = '0;
        last_win  = '0;
    endtask

    // One clock: drive inputs, advance the model at the edge, check just after it.
    task automatic step(input bit rs, input bit v, input bit s, input logic [7:0] d);
        @(negedge clk);
        rst = rs; pix_valid = v; sof = s; pix_in = d;
        @(posedge clk);
        if (!rs) begin
            mr = 0; mc = 0;
            e_wv = 1'b0; e_fd = 1'b0; e_win = '0; win_known = 1'b1;
        end else if (v) begin
            if (s) begin
                mr = 0; mc = 0;
            end
            img[mr][mc] = d;
            e_wv = (mr >= 2) && (mc >= 2);
            e_fd = (mr == H - 1) && (mc == W - 1);
            win_known = e_wv;
            if (e_wv) begin
                e_win = '0;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        e_win = (e_win << 8) | 72'(img[mr - 2 + i][mc - 2 + j]);
            end
            mc++;
            if (mc == W) begin
                mc = 0;
                mr = (mr == H - 1) ? 0 : mr + 1;
            end
        end else begin
            e_wv = 1'b0;
            e_fd = 1'b0;
        end
        #1;
        chk("win_valid", 72'(win_valid), 72'(e_wv));
        chk("frame_done", 72'(frame_done), 72'(e_fd));
        if (win_known) chk("window", dut_win(), e_win);
        if (win_valid === 1'b1) begin
            if (win_cnt == 0) first_win = dut_win();
            last_win = dut_win();
            win_cnt++;
        end
        if (frame_done === 1'b1) fd_cnt++;
    endtask

    // Sends pixels [0, npix) of a frame, value base+4r+c or random, optional random gaps.
    task automatic send_pixels(input int base, input int npix, input bit gaps, input bit rnd);
        for (int k = 0; k < npix; k++) begin
            if (gaps) begin
                int ng = $urandom_range(0, 2);
                for (int g = 0; g < ng; g++) step(1'b1, 1'b0, 1'b0, 8'($urandom));
            end
            step(1'b1, 1'b1, k == 0, rnd ? 8'($urandom) : 8'(base + k));
        end
    endtask

    localparam logic [71:0] FIRST_WIN = 72'h00_01_02_04_05_06_08_09_0A;
    localparam logic [71:0] LAST_WIN  = 72'h05_06_07_09_0A_0B_0D_0E_0F;

    initial begin
        // Reset held two cycles with a valid 0xFF pixel presented.
        step(1'b0, 1'b1, 1'b0, 8'hFF);
        step(1'b0, 1'b1, 1'b0, 8'hFF);

        // Full frame straight out of reset, no sof on the first pixel.
        clear_obs();
        for (int k = 0; k < W * H; k++) step(1'b1, 1'b1, 1'b0, 8'(k));
        chk("full_count", 72'(win_cnt), 72'd4);
        chk("full_first", first_win, FIRST_WIN);
        chk("full_last", last_win, LAST_WIN);
        chk("full_done", 72'(fd_cnt), 72'd1);

        // Same frame with random valid gaps.
        clear_obs();
        send_pixels(0, W * H, 1'b1, 1'b0);
        chk("gap_count", 72'(win_cnt), 72'd4);
        chk("gap_first", first_win, FIRST_WIN);
        chk("gap_last", last_win, LAST_WIN);
        chk("gap_done", 72'(fd_cnt), 72'd1);

        // sof at row 1, col 2 aborts the frame; only the restarted frame completes.
        clear_obs();
        send_pixels(200, 6, 1'b0, 1'b0);
        send_pixels(0, W * H, 1'b0, 1'b0);
        chk("sof_count", 72'(win_cnt), 72'd4);
        chk("sof_first", first_win, FIRST_WIN);
        chk("sof_done", 72'(fd_cnt), 72'd1);

        // Reset at row 2, col 3, then a fresh frame without sof.
        send_pixels(150, 11, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 8'hEE);
        clear_obs();
        for (int k = 0; k < W * H; k++) step(1'b1, 1'b1, 1'b0, 8'(k));
        chk("rst_count", 72'(win_cnt), 72'd4);
        chk("rst_first", first_win, FIRST_WIN);
        chk("rst_last", last_win, LAST_WIN);
        chk("rst_done", 72'(fd_cnt), 72'd1);

        // Back-to-back frames, second offset by 100.
        clear_obs();
        send_pixels(0, W * H, 1'b0, 1'b0);
        send_pixels(100, W * H, 1'b0, 1'b0);
        chk("b2b_count", 72'(win_cnt), 72'd8);
        chk("b2b_last", last_win, LAST_WIN + {9{8'd100}});
        chk("b2b_done", 72'(fd_cnt), 72'd2);

        // Random data frames with random gaps, checked by the model per cycle.
        for (int f = 0; f < 4; f++) begin
            clear_obs();
            send_pixels(0, W * H, 1'b1, 1'b1);
            chk("rnd_count", 72'(win_cnt), 72'd4);
            chk("rnd_done", 72'(fd_cnt), 72'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
